// File: rtl/lcd_timing_pkg.sv
// Shared types and helpers for the RGB-LCD timing controller.
// Optional build macro: LCD_PATTERN_EN (colour-bar test pattern support).
package lcd_timing_pkg;

    // Frame-level controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } lcd_state_e;

    // RGB565 -> RGB888 by replicating the MSBs into the new low bits
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    // Colour-bar table: black, red, green, yellow, blue, magenta, cyan, white
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'h000000;
            3'd1:    c = 24'hFF0000;
            3'd2:    c = 24'h00FF00;
            3'd3:    c = 24'hFFFF00;
            3'd4:    c = 24'h0000FF;
            3'd5:    c = 24'hFF00FF;
            3'd6:    c = 24'h00FFFF;
            default: c = 24'hFFFFFF;
        endcase
        return c;
    endfunction

    // First active-relative pixel of bar k: smallest x with x*8 >= k*active
    function automatic int bar_start(input int k, input int active);
        return (k * active + 7) / 8;
    endfunction

endpackage

// File: rtl/rgb_lcd_timing_ctrl_if.sv
// Line-FIFO read port between the pixel FIFO and the LCD timing controller.
// Handshake: FIFO_RE is a pop request that the controller only raises while
// FIFO_Empty=0 (empty acts as not-valid); a pop issued in cycle N presents its
// word on FIFO_Data during cycle N+1. FIFO_RST flushes the FIFO while high.
interface rgb_lcd_timing_ctrl_if;
    logic        FIFO_Empty;
    logic [15:0] FIFO_Data;
    logic        FIFO_RE;
    logic        FIFO_RST;

    modport master (input FIFO_Empty, input FIFO_Data, output FIFO_RE, output FIFO_RST);
    modport slave  (output FIFO_Empty, output FIFO_Data, input FIFO_RE, input FIFO_RST);
endinterface

// File: rtl/lcd_axis_counter.sv
// One timing axis (horizontal or vertical): sync, back porch, active, front porch.
module lcd_axis_counter #(
    parameter int SYNC   = 2,
    parameter int BP     = 3,
    parameter int ACTIVE = 8,
    parameter int FP     = 1,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             in_sync,
    output logic             in_active,
    output logic             wrap
);
    localparam int               TOTAL     = SYNC + BP + ACTIVE + FP;
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BP + ACTIVE);

    assign wrap      = inc && (cnt == LAST);
    assign in_sync   = (cnt < SYNC_END);
    assign in_active = (cnt >= ACT_START) && (cnt < ACT_END);

    // Free-running position counter, cleared while the axis is stopped
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (wrap) cnt <= '0;
        else if (inc)  cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/rgb_lcd_timing_ctrl.sv
// RGB-LCD timing generator and FIFO-to-pixel streamer.
// Counter stage -> stage 1 (flags, FIFO word arrives) -> stage 2 (panel pins).
// Optional build macro: LCD_PATTERN_EN adds PatternSel and colour-bar output.
module rgb_lcd_timing_ctrl
    import lcd_timing_pkg::*;
#(
    parameter int          H_ACTIVE     = 800,
    parameter int          H_FP         = 40,
    parameter int          H_SYNC       = 48,
    parameter int          H_BP         = 168,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 13,
    parameter int          V_SYNC       = 3,
    parameter int          V_BP         = 29,
    parameter logic        HS_POL       = 1'b0,
    parameter logic        VS_POL       = 1'b0,
    parameter int          CNT_W        = 12,
    parameter int          FIFO_RST_LEN = 20,
    parameter logic [23:0] UF_COLOR     = 24'hFF0000
) (
    input  logic                        PixelClk,
    input  logic                        RST,
    input  logic                        Enable,
`ifdef LCD_PATTERN_EN
    input  logic                        PatternSel,
`endif
    rgb_lcd_timing_ctrl_if.master       fifo,
    output logic                        LCD_DE,
    output logic                        LCD_HSYNC,
    output logic                        LCD_VSYNC,
    output logic [7:0]                  LCD_R,
    output logic [7:0]                  LCD_G,
    output logic [7:0]                  LCD_B,
    output logic                        FrameStart,
    output logic                        Underflow,
    input  logic                        UnderflowClr,
    output logic [1:0]                  dbg_state
);
    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_ARM  = 2'(ST_ARM);
    localparam logic [1:0] S_RUN  = 2'(ST_RUN);

    logic [1:0]       state, state_nxt;
    logic             running;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_sync, h_act, h_wrap;
    logic             v_sync, v_act, v_wrap;
    logic             act0, de0, hs0, vs0, slot0, uf0;
    logic             de1, hs1, vs1, uf1;
    logic [23:0]      pix_nxt;

    assign running   = (state != S_IDLE);
    assign dbg_state = state;

    lcd_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)) u_h_cnt (
        .clk(PixelClk), .rst(RST), .clr(!running || !Enable), .inc(running),
        .cnt(h_cnt), .in_sync(h_sync), .in_active(h_act), .wrap(h_wrap)
    );

    lcd_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)) u_v_cnt (
        .clk(PixelClk), .rst(RST), .clr(!running || !Enable), .inc(h_wrap),
        .cnt(v_cnt), .in_sync(v_sync), .in_active(v_act), .wrap(v_wrap)
    );

    // Frame-level sequencing; v_wrap only fires on the last pixel of a frame
    always_comb begin
        state_nxt = state;
        if (!Enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_ARM;
                S_ARM:   if (v_wrap && !fifo.FIFO_Empty) state_nxt = S_RUN;
                S_RUN:   state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Counter stage: timing flags and the pop decision
    assign act0 = h_act && v_act;
    assign de0  = (state == S_RUN) && act0;
    assign hs0  = (running && h_sync) ? HS_POL : ~HS_POL;
    assign vs0  = (running && v_sync) ? VS_POL : ~VS_POL;
`ifdef LCD_PATTERN_EN
    assign slot0 = de0 && !PatternSel;
`else
    assign slot0 = de0;
`endif
    assign uf0          = slot0 && fifo.FIFO_Empty;
    assign fifo.FIFO_RE = slot0 && !fifo.FIFO_Empty;
    // Flush lands inside vsync on line 0, well clear of any active pop
    assign fifo.FIFO_RST = !running || ((v_cnt == '0) && (h_cnt < CNT_W'(FIFO_RST_LEN)));
    assign FrameStart    = running && (h_cnt == '0) && (v_cnt == '0);

    // Stage 1: timing flags travel alongside the pixel being fetched
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            de1 <= 1'b0;
            hs1 <= ~HS_POL;
            vs1 <= ~VS_POL;
            uf1 <= 1'b0;
        end else begin
            de1 <= de0;
            hs1 <= hs0;
            vs1 <= vs0;
            uf1 <= uf0;
        end
    end

`ifdef LCD_PATTERN_EN
    logic [2:0] bar0, bar1;
    logic       pat1;

    // Bar index by comparing against precomputed bar boundaries
    always_comb begin
        bar0 = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= CNT_W'(H_SYNC + H_BP + bar_start(k, H_ACTIVE))) bar0 = bar0 + 3'd1;
        end
    end

    // Stage 1: pattern select and bar index
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            pat1 <= 1'b0;
            bar1 <= 3'd0;
        end else begin
            pat1 <= PatternSel;
            bar1 <= bar0;
        end
    end
`endif

    // Pixel source selection for the pin stage
    always_comb begin
        pix_nxt = 24'h000000;
        if (de1) begin
            if (uf1) pix_nxt = UF_COLOR;
            else     pix_nxt = rgb565_to_888(fifo.FIFO_Data);
`ifdef LCD_PATTERN_EN
            if (pat1) pix_nxt = bar_color(bar1);
`endif
        end
    end

    // Stage 2: panel pins
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            LCD_DE               <= 1'b0;
            LCD_HSYNC            <= ~HS_POL;
            LCD_VSYNC            <= ~VS_POL;
            {LCD_R, LCD_G, LCD_B} <= 24'h000000;
        end else begin
            LCD_DE               <= de1;
            LCD_HSYNC            <= hs1;
            LCD_VSYNC            <= vs1;
            {LCD_R, LCD_G, LCD_B} <= pix_nxt;
        end
    end

    // Sticky underflow flag; a same-cycle clear drops the new event
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST)               Underflow <= 1'b0;
        else if (UnderflowClr) Underflow <= 1'b0;
        else if (uf0)          Underflow <= 1'b1;
    end
endmodule

// File: tb/tb_rgb_lcd_timing_ctrl.sv
// Bench for rgb_lcd_timing_ctrl on a small panel geometry.
// Optional build macro: LCD_PATTERN_EN (adds a colour-bar phase).
module tb_rgb_lcd_timing_ctrl;
    localparam int H_ACTIVE = 8, H_FP = 1, H_SYNC = 2, H_BP = 3;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int F_TOTAL = H_TOTAL * V_TOTAL;
    localparam int RST_LEN = 2;
    localparam logic HS_POL = 1'b1, VS_POL = 1'b1;
    localparam logic [23:0] UF_COLOR = 24'hFF0000;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } pins_t;

    typedef struct {
        logic [15:0] data;
        logic [23:0] rgb;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic uf_clr = 1'b0;
    always #5 clk = ~clk;

    logic       de, hs, vs, fs, uf_flag;
    logic [7:0] r, g, b;
    logic [1:0] dbg_state;
`ifdef LCD_PATTERN_EN
    logic pattern_sel = 1'b0;
`endif

    rgb_lcd_timing_ctrl_if fifo_bus();

    rgb_lcd_timing_ctrl #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(12), .FIFO_RST_LEN(RST_LEN),
        .UF_COLOR(UF_COLOR)
    ) dut (
        .PixelClk(clk), .RST(rst), .Enable(enable),
`ifdef LCD_PATTERN_EN
        .PatternSel(pattern_sel),
`endif
        .fifo(fifo_bus),
        .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
        .LCD_R(r), .LCD_G(g), .LCD_B(b),
        .FrameStart(fs), .Underflow(uf_flag), .UnderflowClr(uf_clr),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [15:0] pix_mem [0:1023];
    int drv_idx = 0, mdl_idx = 0;
    logic re_seen = 1'b0;
    pins_t hist[$];
    pins_t idle_p;
    int pos = -1, frame_m = 0, epoch = 0;
    logic run_m = 1'b0, flag_m = 1'b0;
    logic [23:0] bars [8];
    vec_t vec [6];
    logic [23:0] cap_q[$];

    int arm_cyc [3];
    int first_re [3];
    int first_de [3];
    int re_cnt [3];
    int de_f1 = 0, hs_f1 = 0, vs_f1 = 0, frst_f1 = 0, re_f1 = 0;
    int re_f2 = 0, ufpix_f2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RGB565 -> RGB888 from channel values: shift up, fill low bits with the top bits
    function automatic logic [23:0] expand(input logic [15:0] d);
        int r5, g6, b5;
        r5 = int'(d) >> 11;
        g6 = (int'(d) >> 5) & 63;
        b5 = int'(d) & 31;
        return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
    endfunction

    task automatic model_reset();
        pos = -1; frame_m = 0; run_m = 1'b0; flag_m = 1'b0;
        hist.delete();
        hist.push_back(idle_p);
        hist.push_back(idle_p);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_de"}, 32'(de), 32'(0));
        check({tag, "_hs"}, 32'(hs), 32'(!HS_POL));
        check({tag, "_vs"}, 32'(vs), 32'(!VS_POL));
        check({tag, "_rgb"}, 32'({r, g, b}), 32'(0));
        check({tag, "_re"}, 32'(fifo_bus.FIFO_RE), 32'(0));
        check({tag, "_frst"}, 32'(fifo_bus.FIFO_RST), 32'(1));
        check({tag, "_fs"}, 32'(fs), 32'(0));
        check({tag, "_uf"}, 32'(uf_flag), 32'(0));
    endtask

    // One clock: compare at negedge, advance the model, serve the FIFO pop
    task automatic cycle();
        logic idle, act, pat, slot, e_re, e_uf, e_frst, e_fs;
        int h, v;
        pins_t cur, exp_p;
        @(negedge clk);
        idle = (pos < 0);
        h = idle ? 0 : pos % H_TOTAL;
        v = idle ? 0 : pos / H_TOTAL;
        pat = 1'b0;
`ifdef LCD_PATTERN_EN
        pat = pattern_sel;
`endif
        act = !idle && h >= H_SYNC + H_BP && h < H_SYNC + H_BP + H_ACTIVE
                    && v >= V_SYNC + V_BP && v < V_SYNC + V_BP + V_ACTIVE;
        cur.de = act && run_m;
        slot   = cur.de && !pat;
        e_re   = slot && !fifo_bus.FIFO_Empty;
        e_uf   = slot && fifo_bus.FIFO_Empty;
        cur.hs = (!idle && h < H_SYNC) ? HS_POL : !HS_POL;
        cur.vs = (!idle && v < V_SYNC) ? VS_POL : !VS_POL;
        cur.rgb = 24'h0;
        if (cur.de) begin
            if (pat)       cur.rgb = bars[(h - H_SYNC - H_BP) * 8 / H_ACTIVE];
            else if (e_uf) cur.rgb = UF_COLOR;
            else           cur.rgb = expand(pix_mem[mdl_idx]);
        end
        e_frst = idle || (v == 0 && h < RST_LEN);
        e_fs   = !idle && pos == 0;
        exp_p  = hist.pop_front();
        hist.push_back(cur);

        check("fifo_re", 32'(fifo_bus.FIFO_RE), 32'(e_re));
        check("fifo_rst", 32'(fifo_bus.FIFO_RST), 32'(e_frst));
        check("frame_start", 32'(fs), 32'(e_fs));
        check("underflow", 32'(uf_flag), 32'(flag_m));
        check("lcd_de", 32'(de), 32'(exp_p.de));
        check("lcd_hsync", 32'(hs), 32'(exp_p.hs));
        check("lcd_vsync", 32'(vs), 32'(exp_p.vs));
        check("lcd_rgb", 32'({r, g, b}), 32'(exp_p.rgb));

        // measurements taken from the DUT pins
        if (!idle) begin
            if (fifo_bus.FIFO_RE && first_re[epoch] < 0) first_re[epoch] = cyc;
            if (de && first_de[epoch] < 0) first_de[epoch] = cyc;
            if (fifo_bus.FIFO_RE) re_cnt[epoch]++;
            if (frame_m == 1 && epoch == 0) begin
                de_f1 += int'(de);
                hs_f1 += int'(hs == HS_POL);
                vs_f1 += int'(vs == VS_POL);
                frst_f1 += int'(fifo_bus.FIFO_RST);
                re_f1 += int'(fifo_bus.FIFO_RE);
            end
            if (frame_m == 1 && epoch != 1 && de) cap_q.push_back({r, g, b});
            if (frame_m == 2 && epoch == 0) begin
                re_f2 += int'(fifo_bus.FIFO_RE);
                ufpix_f2 += int'(de && {r, g, b} == UF_COLOR);
                if (pos == 4 * H_TOTAL)     check("uf_sticky", 32'(uf_flag), 32'(1));
                if (pos == 4 * H_TOTAL + 9) check("uf_clr_wins", 32'(uf_flag), 32'(0));
            end
        end

        // advance the reference model
        if (e_re) mdl_idx++;
        if (uf_clr)    flag_m = 1'b0;
        else if (e_uf) flag_m = 1'b1;
        if (!enable) begin
            pos = -1; run_m = 1'b0;
        end else if (idle) begin
            pos = 0; frame_m = 0; run_m = 1'b0; arm_cyc[epoch] = cyc + 1;
        end else if (pos == F_TOTAL - 1) begin
            if (!run_m && !fifo_bus.FIFO_Empty) run_m = 1'b1;
            pos = 0; frame_m++;
        end else begin
            pos++;
        end
        re_seen = fifo_bus.FIFO_RE;

        @(posedge clk);
        #1;
        cyc++;
        if (re_seen) begin
            fifo_bus.FIFO_Data = pix_mem[drv_idx];
            drv_idx++;
        end
    endtask

    // Inputs for the upcoming cycle, keyed on the model's frame position
    task automatic drive_inputs();
        int h, v;
        h = (pos < 0) ? 0 : pos % H_TOTAL;
        v = (pos < 0) ? 0 : pos / H_TOTAL;
        fifo_bus.FIFO_Empty = 1'b0;
        uf_clr = 1'b0;
        if (epoch == 0 && pos >= 0 && frame_m == 2) begin
            if (v == 3 && h >= 6 && h <= 8) fifo_bus.FIFO_Empty = 1'b1;
            if (v == 4 && h == 1) uf_clr = 1'b1;
            if (v == 4 && h == 7) begin
                fifo_bus.FIFO_Empty = 1'b1;
                uf_clr = 1'b1;
            end
        end else if (epoch == 0 && pos >= 0 && frame_m >= 3) begin
            fifo_bus.FIFO_Empty = ($urandom_range(0, 7) == 0);
            uf_clr = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        int guard;
        logic [15:0] d;
        bars = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
                 24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF};
        vec[0] = '{16'hF800, 24'hFF0000};
        vec[1] = '{16'h07E0, 24'h00FF00};
        vec[2] = '{16'h0841, 24'h080808};
        vec[3] = '{16'h001F, 24'h0000FF};
        vec[4] = '{16'hFFFF, 24'hFFFFFF};
        vec[5] = '{16'h0000, 24'h000000};
        for (int i = 0; i < 6; i++) pix_mem[i] = vec[i].data;
        for (int i = 6; i < 1024; i++) begin
            d = 16'($urandom_range(0, 65535));
            if (d == 16'hF800) d = 16'hF801;
            pix_mem[i] = d;
        end
        for (int i = 0; i < 3; i++) begin
            arm_cyc[i] = -1; first_re[i] = -1; first_de[i] = -1; re_cnt[i] = 0;
        end
        idle_p.de = 1'b0; idle_p.hs = !HS_POL; idle_p.vs = !VS_POL; idle_p.rgb = 24'h0;
        model_reset();
        fifo_bus.FIFO_Empty = 1'b0;
        fifo_bus.FIFO_Data = 16'h0;

        // power-on reset
        #1 rst = 1'b1;
        #2 reset_checks("por");
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // epoch 0: ARM frame, table pixels, underflow cases, random traffic
        enable = 1'b1;
        guard = 0;
        while (!(frame_m == 5 && pos == 3 * H_TOTAL + 8) && guard < 1000) begin
            drive_inputs();
            cycle();
            guard++;
        end
        check("reach_mid_frame", 32'(guard < 1000), 32'(1));

        // asynchronous reset in the middle of an active line
        fifo_bus.FIFO_Empty = 1'b0;
        uf_clr = 1'b0;
        #2 rst = 1'b1;
        #1 reset_checks("async");
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        model_reset();
        epoch = 1;

        // epoch 1: Enable still high, so the controller re-arms by itself
        for (int i = 0; i < 2 * F_TOTAL + 2; i++) begin
            drive_inputs();
            cycle();
        end

        // Enable low: back to idle, pins drain to inactive
        enable = 1'b0;
        repeat (5) cycle();

`ifdef LCD_PATTERN_EN
        epoch = 2;
        cap_q.delete();
        pattern_sel = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 2 * F_TOTAL + 2; i++) begin
            drive_inputs();
            cycle();
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("bar_%0d", i), 32'(cap_q.size() > i ? cap_q[i] : 24'hx), 32'(bars[i]));
        check("pattern_no_pop", 32'(re_cnt[2]), 32'(0));
        enable = 1'b0;
        pattern_sel = 1'b0;
        repeat (3) cycle();
`endif

        // frame-level results
        check("arm_to_first_re", 32'(first_re[0] - arm_cyc[0]), 32'(F_TOTAL + 2 * H_TOTAL + 5));
        check("re_to_de", 32'(first_de[0] - first_re[0]), 32'(2));
        check("rearm_to_first_re", 32'(first_re[1] - arm_cyc[1]), 32'(F_TOTAL + 2 * H_TOTAL + 5));
        check("rearm_re_to_de", 32'(first_de[1] - first_re[1]), 32'(2));
        check("de_per_frame", 32'(de_f1), 32'(32));
        check("re_per_frame", 32'(re_f1), 32'(32));
        check("hsync_per_frame", 32'(hs_f1), 32'(2 * V_TOTAL));
        check("vsync_per_frame", 32'(vs_f1), 32'(H_TOTAL));
        check("fifo_rst_per_frame", 32'(frst_f1), 32'(RST_LEN));
        check("re_uf_frame", 32'(re_f2), 32'(28));
        check("uf_pixels", 32'(ufpix_f2), 32'(4));
`ifndef LCD_PATTERN_EN
        for (int i = 0; i < 6; i++)
            check($sformatf("rgb_vec_%0d", i), 32'(cap_q.size() > i ? cap_q[i] : 24'hx), 32'(vec[i].rgb));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
